divider_result_adjust: RTL

// - Downstream stage of the signed integer divider. Consumes its truncated quotient/remainder/divide_by_zero result.
// - Rewrites each result into the convention chosen per transaction: truncated, floored or Euclidean.
// - Keeps a sticky divide-by-zero flag and a saturating event counter.
// - Fully pipelined valid/ready stage with a 2-entry skid buffer: full throughput, 1-cycle latency.

---
 rtl/divider_result_adjust.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/divider_result_adjust.sv
// divider_result_adjust
// Post-processing stage for the signed integer divider. Takes a truncated
// quotient/remainder pair and rewrites it as a truncated, floored or
// Euclidean result, selected per transaction by 'mode'. It also keeps a
// sticky divide-by-zero flag and a saturating divide-by-zero event counter.
// Valid/ready stage with a 2-entry skid buffer, so input_ready is a register
// and never depends combinationally on output_ready.
module divider_result_adjust #(
  parameter int WORD_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic [WORD_WIDTH-1:0]  quotient_in,
  input  logic [WORD_WIDTH-1:0]  remainder_in,
  input  logic [WORD_WIDTH-1:0]  divisor_in,
  input  logic                   dbz_in,
  input  logic [1:0]             mode,
  output logic                   output_valid,
  input  logic                   output_ready,
  output logic [WORD_WIDTH-1:0]  quotient,
  output logic [WORD_WIDTH-1:0]  remainder,
  output logic                   divide_by_zero,
  output logic                   dbz_sticky,
  output logic [COUNT_WIDTH-1:0] dbz_count
);

  localparam logic [WORD_WIDTH-1:0]  WORD_ZERO = {WORD_WIDTH{1'b0}};
  localparam logic [WORD_WIDTH-1:0]  WORD_ONE  = {{(WORD_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO  = {COUNT_WIDTH{1'b0}};
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = {COUNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  // Rewrites a truncated {q, r} pair into the requested convention.
  // Divide-by-zero results are never adjusted. Arithmetic wraps at
  // WORD_WIDTH; a valid divider result cannot overflow here because any
  // non-zero remainder implies |d| >= 2 and |r| < |d|.
  function automatic logic [2*WORD_WIDTH-1:0] adjust_result(
    input logic [WORD_WIDTH-1:0] q,
    input logic [WORD_WIDTH-1:0] r,
    input logic [WORD_WIDTH-1:0] d,
    input logic [1:0]            m,
    input logic                  dbz
  );
    logic [WORD_WIDTH-1:0] q_v;
    logic [WORD_WIDTH-1:0] r_v;
    logic                  r_neg;
    logic                  d_neg;
    logic                  r_nz;
    logic                  d_nz;
    q_v   = q;
    r_v   = r;
    r_neg = r[WORD_WIDTH-1];
    d_neg = d[WORD_WIDTH-1];
    r_nz  = (r != WORD_ZERO);
    d_nz  = (d != WORD_ZERO);
    if (dbz) begin
      q_v = q;
      r_v = r;
    end else begin
      case (m)
        2'd1: begin
          // floor: remainder takes the sign of the divisor
          if (r_nz && (r_neg != d_neg)) begin
            q_v = q - WORD_ONE;
            r_v = r + d;
          end else begin
            q_v = q;
            r_v = r;
          end
        end
        2'd2: begin
          // Euclid: remainder is never negative
          if (r_neg && !d_neg && d_nz) begin
            q_v = q - WORD_ONE;
            r_v = r + d;
          end else if (r_neg && d_neg) begin
            q_v = q + WORD_ONE;
            r_v = r - d;
          end else begin
            q_v = q;
            r_v = r;
          end
        end
        default: begin
          // modes 0 and 3: truncated result passes through
          q_v = q;
          r_v = r;
        end
      endcase
    end
    return {q_v, r_v};
  endfunction

  state_t                 state_r;
  state_t                 state_nx_s;
  logic                   input_ready_r;
  logic                   output_valid_r;
  logic [WORD_WIDTH-1:0]  q_out_r;
  logic [WORD_WIDTH-1:0]  r_out_r;
  logic                   dbz_out_r;
  logic [WORD_WIDTH-1:0]  q_skid_r;
  logic [WORD_WIDTH-1:0]  r_skid_r;
  logic                   dbz_skid_r;
  logic                   sticky_r;
  logic [COUNT_WIDTH-1:0] count_r;

  logic                    accept_s;
  logic                    out_xfer_s;
  logic                    load_out_new_s;
  logic                    load_out_skid_s;
  logic                    load_skid_s;
  logic [2*WORD_WIDTH-1:0] adj_s;
  logic [WORD_WIDTH-1:0]   adj_q_s;
  logic [WORD_WIDTH-1:0]   adj_r_s;

  assign accept_s   = input_valid && input_ready_r;
  assign out_xfer_s = output_valid_r && output_ready;
  assign adj_q_s    = adj_s[2*WORD_WIDTH-1:WORD_WIDTH];
  assign adj_r_s    = adj_s[WORD_WIDTH-1:0];

  assign input_ready    = input_ready_r;
  assign output_valid   = output_valid_r;
  assign quotient       = q_out_r;
  assign remainder      = r_out_r;
  assign divide_by_zero = dbz_out_r;
  assign dbz_sticky     = sticky_r;
  assign dbz_count      = count_r;

  // Adjust the incoming result so it is ready to be captured on accept.
  always_comb begin
    adj_s = adjust_result(quotient_in, remainder_in, divisor_in, mode, dbz_in);
  end

  // Skid-buffer next state and register load selects.
  always_comb begin
    state_nx_s      = state_r;
    load_out_new_s  = 1'b0;
    load_out_skid_s = 1'b0;
    load_skid_s     = 1'b0;
    case (state_r)
      ST_EMPTY: begin
        if (accept_s) begin
          state_nx_s     = ST_ONE;
          load_out_new_s = 1'b1;
        end else begin
          state_nx_s = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (accept_s && out_xfer_s) begin
          state_nx_s     = ST_ONE;
          load_out_new_s = 1'b1;
        end else if (accept_s) begin
          state_nx_s  = ST_TWO;
          load_skid_s = 1'b1;
        end else if (out_xfer_s) begin
          state_nx_s = ST_EMPTY;
        end else begin
          state_nx_s = ST_ONE;
        end
      end
      ST_TWO: begin
        if (out_xfer_s) begin
          state_nx_s      = ST_ONE;
          load_out_skid_s = 1'b1;
        end else begin
          state_nx_s = ST_TWO;
        end
      end
      default: begin
        state_nx_s = ST_EMPTY;
      end
    endcase
  end

  // State register plus registered handshake flags derived from next state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r        <= ST_EMPTY;
      input_ready_r  <= 1'b1;
      output_valid_r <= 1'b0;
    end else begin
      state_r        <= state_nx_s;
      input_ready_r  <= (state_nx_s != ST_TWO);
      output_valid_r <= (state_nx_s != ST_EMPTY);
    end
  end

  // Output and skid data registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      q_out_r    <= WORD_ZERO;
      r_out_r    <= WORD_ZERO;
      dbz_out_r  <= 1'b0;
      q_skid_r   <= WORD_ZERO;
      r_skid_r   <= WORD_ZERO;
      dbz_skid_r <= 1'b0;
    end else begin
      if (load_out_new_s) begin
        q_out_r   <= adj_q_s;
        r_out_r   <= adj_r_s;
        dbz_out_r <= dbz_in;
      end else if (load_out_skid_s) begin
        q_out_r   <= q_skid_r;
        r_out_r   <= r_skid_r;
        dbz_out_r <= dbz_skid_r;
      end
      if (load_skid_s) begin
        q_skid_r   <= adj_q_s;
        r_skid_r   <= adj_r_s;
        dbz_skid_r <= dbz_in;
      end
    end
  end

  // Sticky divide-by-zero flag and saturating event counter.
  always_ff @(posedge clock) begin
    if (clear) begin
      sticky_r <= 1'b0;
      count_r  <= CNT_ZERO;
    end else if (accept_s && dbz_in) begin
      sticky_r <= 1'b1;
      if (count_r != CNT_MAX) begin
        count_r <= count_r + CNT_ONE;
      end
    end
  end

endmodule
